// File: rtl/connect4_pkg.sv
// Shared board geometry, FSM state encoding and cell indexing for the
// connect-four move controller.
package connect4_pkg;

  localparam int unsigned COLS   = 7;
  localparam int unsigned ROWS   = 6;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned CELL_W = 6;
  localparam int unsigned MOVE_W = 6;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLACE = 2'd1,
    ST_CHECK = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Flat board bit for a (row, column) pair.
  function automatic logic [CELL_W-1:0] cell_index(input logic [ROW_W-1:0] h,
                                                   input logic [COL_W-1:0] l);
    return CELL_W'(h * COLS + l);
  endfunction

endpackage

// File: rtl/connect4_move_controller_if.sv
// Request/board bus between the front end, the move controller and win_logic.
interface connect4_move_controller_if;
  import connect4_pkg::*;

  logic             new_game;
  logic             move_valid;
  logic [COL_W-1:0] move_col;
  logic             move_ready;
  logic             wongame;
  logic [COL_W-1:0] location;
  logic [ROW_W-1:0] height;
  logic             player;
  logic [CELLS-1:0] player_register;
  logic [CELLS-1:0] onoff_register;
  logic             illegal;
  logic             move_done;
  logic             game_over;
  logic             winner;
  logic             draw;

  modport master (
    output new_game, move_valid, move_col, wongame,
    input  move_ready, location, height, player, player_register,
           onoff_register, illegal, move_done, game_over, winner, draw
  );

  modport slave (
    input  new_game, move_valid, move_col, wongame,
    output move_ready, location, height, player, player_register,
           onoff_register, illegal, move_done, game_over, winner, draw
  );

endinterface

// File: rtl/column_height_tracker.sv
// Per-column fill counters: landing row lookup, full flags, increment and clear.
module column_height_tracker
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [COL_W-1:0] inc_col,
  input  logic [COL_W-1:0] sel_col,
  output logic [ROW_W-1:0] sel_height_c,
  output logic [COLS-1:0]  full_c
);

  logic [ROW_W-1:0] height_q [COLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      height_q <= '{default: '0};
    end else if (clear) begin
      height_q <= '{default: '0};
    end else if (inc && (inc_col < COL_W'(COLS))) begin
      height_q[inc_col] <= height_q[inc_col] + ROW_W'(1);
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_full
    assign full_c[gi] = (height_q[gi] == ROW_W'(ROWS));
  end

  // Out-of-range columns read as empty; the controller rejects them anyway.
  always_comb begin
    sel_height_c = '0;
    if (sel_col < COL_W'(COLS)) sel_height_c = height_q[sel_col];
  end

endmodule

// File: rtl/connect4_move_controller.sv
// Move sequencer: accepts column drops, writes the board, waits for win_logic
// to settle, then resolves win / draw / next turn.
module connect4_move_controller
  import connect4_pkg::*;
#(
  parameter int unsigned CHECK_WAIT = 1
) (
  input logic                       clock,
  input logic                       resetn,
  connect4_move_controller_if.slave bus
);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  location_q, location_d;
  logic [ROW_W-1:0]  height_q, height_d;
  logic              player_q, player_d;
  logic [CELLS-1:0]  onoff_q, onoff_d;
  logic [CELLS-1:0]  owner_q, owner_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              done_q, done_d;
  logic              over_q, over_d;
  logic              winner_q, winner_d;
  logic              draw_q, draw_d;

  logic              trk_clear, trk_inc;
  logic [ROW_W-1:0]  sel_height_c;
  logic [COLS-1:0]   full_c;
  logic              col_bad_c;
  logic [CELL_W-1:0] cell_c;

  column_height_tracker u_heights (
    .clk          (clock),
    .rst_n        (resetn),
    .clear        (trk_clear),
    .inc          (trk_inc),
    .inc_col      (location_q),
    .sel_col      (bus.move_col),
    .sel_height_c (sel_height_c),
    .full_c       (full_c)
  );

  assign cell_c    = cell_index(height_q, location_q);
  assign col_bad_c = (bus.move_col >= COL_W'(COLS)) ? 1'b1 : full_c[bus.move_col];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      location_q <= '0;
      height_q   <= '0;
      player_q   <= 1'b0;
      onoff_q    <= '0;
      owner_q    <= '0;
      moves_q    <= '0;
      wait_q     <= '0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= 1'b0;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      location_q <= location_d;
      height_q   <= height_d;
      player_q   <= player_d;
      onoff_q    <= onoff_d;
      owner_q    <= owner_d;
      moves_q    <= moves_d;
      wait_q     <= wait_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
    end
  end

  // new_game wins over everything, including a same-cycle request.
  always_comb begin
    state_d    = state_q;
    location_d = location_q;
    height_d   = height_q;
    player_d   = player_q;
    onoff_d    = onoff_q;
    owner_d    = owner_q;
    moves_d    = moves_q;
    wait_d     = wait_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    illegal_d  = 1'b0;
    done_d     = 1'b0;
    over_d     = 1'b0;
    trk_clear  = 1'b0;
    trk_inc    = 1'b0;

    if (bus.new_game) begin
      state_d    = ST_IDLE;
      location_d = '0;
      height_d   = '0;
      player_d   = 1'b0;
      onoff_d    = '0;
      owner_d    = '0;
      moves_d    = '0;
      wait_d     = '0;
      winner_d   = 1'b0;
      draw_d     = 1'b0;
      trk_clear  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.move_valid) begin
            if (col_bad_c) begin
              illegal_d = 1'b1;
            end else begin
              location_d = bus.move_col;
              height_d   = sel_height_c;
              state_d    = ST_PLACE;
            end
          end
        end
        ST_PLACE: begin
          onoff_d[cell_c] = 1'b1;
          owner_d[cell_c] = player_q;
          moves_d         = moves_q + MOVE_W'(1);
          wait_d          = WAIT_W'(CHECK_WAIT - 1);
          trk_inc         = 1'b1;
          state_d         = ST_CHECK;
        end
        ST_CHECK: begin
          if (wait_q == '0) begin
            done_d = 1'b1;
            if (bus.wongame) begin
              winner_d = player_q;
              state_d  = ST_OVER;
            end else if (moves_q == MOVE_W'(CELLS)) begin
              draw_d  = 1'b1;
              state_d = ST_OVER;
            end else begin
              player_d = ~player_q;
              state_d  = ST_IDLE;
            end
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        ST_OVER: begin
        end
      endcase
    end

    over_d = (state_d == ST_OVER);
  end

  assign bus.move_ready      = (state_q == ST_IDLE);
  assign bus.location        = location_q;
  assign bus.height          = height_q;
  assign bus.player          = player_q;
  assign bus.player_register = owner_q;
  assign bus.onoff_register  = onoff_q;
  assign bus.illegal         = illegal_q;
  assign bus.move_done       = done_q;
  assign bus.game_over       = over_q;
  assign bus.winner          = winner_q;
  assign bus.draw            = draw_q;

endmodule

// File: tb/tb_connect4_move_controller.sv
// Bench for connect4_move_controller: two instances (settle windows 1 and 4)
// share one stimulus stream and are checked every cycle against a board model.
module tb_connect4_move_controller;

  typedef struct packed {
    logic        ready;
    logic [2:0]  loc;
    logic [2:0]  hgt;
    logic        ply;
    logic [41:0] preg;
    logic [41:0] onoff;
    logic        ill;
    logic        done;
    logic        over;
    logic        win;
    logic        drw;
  } out_t;

  logic       clk;
  logic       resetn;
  logic       new_game;
  logic       move_valid;
  logic [2:0] move_col;
  logic       wongame;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  connect4_move_controller_if bus_a ();
  connect4_move_controller_if bus_b ();

  assign bus_a.new_game   = new_game;
  assign bus_a.move_valid = move_valid;
  assign bus_a.move_col   = move_col;
  assign bus_a.wongame    = wongame;
  assign bus_b.new_game   = new_game;
  assign bus_b.move_valid = move_valid;
  assign bus_b.move_col   = move_col;
  assign bus_b.wongame    = wongame;

  connect4_move_controller #(.CHECK_WAIT(1)) dut_a (.clock(clk), .resetn(resetn), .bus(bus_a));
  connect4_move_controller #(.CHECK_WAIT(4)) dut_b (.clock(clk), .resetn(resetn), .bus(bus_b));

  out_t act_a, act_b;
  assign act_a = {bus_a.move_ready, bus_a.location, bus_a.height, bus_a.player,
                  bus_a.player_register, bus_a.onoff_register, bus_a.illegal,
                  bus_a.move_done, bus_a.game_over, bus_a.winner, bus_a.draw};
  assign act_b = {bus_b.move_ready, bus_b.location, bus_b.height, bus_b.player,
                  bus_b.player_register, bus_b.onoff_register, bus_b.illegal,
                  bus_b.move_done, bus_b.game_over, bus_b.winner, bus_b.draw};

  // Board model: own = -1 empty, else owning player; one copy per instance.
  int own [2][7][6];
  bit m_busy [2];
  int m_k [2];
  bit m_over [2];
  int m_col [2];
  int m_row [2];
  bit m_ply [2];
  int m_moves [2];
  bit e_ill [2];
  bit e_done [2];
  bit e_win [2];
  bit e_drw [2];

  function automatic int cw_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int col_fill(input int i, input int c);
    int n = 0;
    for (int r = 0; r < 6; r++) if (own[i][c][r] >= 0) n++;
    return n;
  endfunction

  task automatic model_clear(input int i);
    for (int c = 0; c < 7; c++) for (int r = 0; r < 6; r++) own[i][c][r] = -1;
    m_busy[i] = 0; m_k[i] = 0; m_over[i] = 0; m_col[i] = 0; m_row[i] = 0;
    m_ply[i] = 0; m_moves[i] = 0; e_ill[i] = 0; e_done[i] = 0; e_win[i] = 0; e_drw[i] = 0;
  endtask

  // One clock edge: m_k counts edges since the request was accepted.
  task automatic model_step(input int i);
    int c;
    c = int'(move_col);
    e_ill[i] = 0;
    e_done[i] = 0;
    if (new_game) begin
      model_clear(i);
      return;
    end
    if (m_busy[i]) begin
      m_k[i]++;
      if (m_k[i] == 1) begin
        own[i][m_col[i]][m_row[i]] = m_ply[i] ? 1 : 0;
        m_moves[i]++;
      end
      if (m_k[i] == 1 + cw_of(i)) begin
        m_busy[i] = 0;
        e_done[i] = 1;
        if (wongame) begin
          m_over[i] = 1; e_win[i] = m_ply[i];
        end else if (m_moves[i] == 42) begin
          m_over[i] = 1; e_drw[i] = 1;
        end else begin
          m_ply[i] = !m_ply[i];
        end
      end
    end else if (!m_over[i] && move_valid) begin
      if (c > 6 || col_fill(i, c) == 6) begin
        e_ill[i] = 1;
      end else begin
        m_col[i] = c; m_row[i] = col_fill(i, c); m_busy[i] = 1; m_k[i] = 0;
      end
    end
  endtask

  function automatic out_t exp_out(input int i);
    out_t o;
    o = '0;
    o.ready = !m_busy[i] && !m_over[i];
    o.loc   = 3'(m_col[i]);
    o.hgt   = 3'(m_row[i]);
    o.ply   = m_ply[i];
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        if (own[i][c][r] >= 0) begin
          o.onoff[r*7 + c] = 1'b1;
          if (own[i][c][r] == 1) o.preg[r*7 + c] = 1'b1;
        end
    o.ill  = e_ill[i];
    o.done = e_done[i];
    o.over = m_over[i];
    o.win  = e_win[i];
    o.drw  = e_drw[i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic cmp(input string tag, input out_t a, input out_t e);
    chk({tag, ".move_ready"},      64'(a.ready), 64'(e.ready));
    chk({tag, ".location"},        64'(a.loc),   64'(e.loc));
    chk({tag, ".height"},          64'(a.hgt),   64'(e.hgt));
    chk({tag, ".player"},          64'(a.ply),   64'(e.ply));
    chk({tag, ".player_register"}, 64'(a.preg),  64'(e.preg));
    chk({tag, ".onoff_register"},  64'(a.onoff), 64'(e.onoff));
    chk({tag, ".illegal"},         64'(a.ill),   64'(e.ill));
    chk({tag, ".move_done"},       64'(a.done),  64'(e.done));
    chk({tag, ".game_over"},       64'(a.over),  64'(e.over));
    chk({tag, ".winner"},          64'(a.win),   64'(e.win));
    chk({tag, ".draw"},            64'(a.drw),   64'(e.drw));
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    cmp("cw1", act_a, exp_out(0));
    cmp("cw4", act_b, exp_out(1));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!((bus_a.move_ready || bus_a.game_over) && (bus_b.move_ready || bus_b.game_over))
           && n < 30) begin
      tick();
      n++;
    end
    chk({tag, ".settle_timeout"}, 64'(n >= 30), 64'd0);
  endtask

  task automatic do_move(input int col, input bit won);
    move_col   = 3'(col);
    move_valid = 1'b1;
    wongame    = won;
    tick();
    move_valid = 1'b0;
    wait_idle("move");
    wongame = 1'b0;
  endtask

  task automatic start_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_col = '0; wongame = 1'b0;
    model_clear(0);
    model_clear(1);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("rst.move_ready", 64'(bus_a.move_ready), 64'd1);
    chk("rst.onoff", 64'(bus_b.onoff_register), 64'd0);

    // Single drop in column 3 with both settle windows.
    move_col = 3'd3; move_valid = 1'b1;
    tick();                                 // T: accepted
    move_valid = 1'b0;
    tick();                                 // T+1: place
    tick();                                 // T+2: cw1 resolves
    chk("t1.done_cw1", 64'(bus_a.move_done), 64'd1);
    chk("t1.onoff", 64'(bus_a.onoff_register), 64'h8);
    chk("t1.preg", 64'(bus_a.player_register), 64'h0);
    chk("t1.player", 64'(bus_a.player), 64'd1);
    tick();
    tick();
    tick();                                 // T+5: cw4 resolves
    chk("t1.done_cw4", 64'(bus_b.move_done), 64'd1);
    wait_idle("t1");

    // Fill column 0, then overflow it and use an out-of-range column.
    start_game();
    for (int k = 0; k < 6; k++) do_move(0, 1'b0);
    move_col = 3'd0; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    chk("t2.illegal_full", 64'(bus_a.illegal), 64'd1);
    chk("t2.onoff", 64'(bus_a.onoff_register), 64'h8_1020_4081);
    chk("t2.preg", 64'(bus_b.player_register), 64'h8_0020_0080);
    chk("t2.player", 64'(bus_a.player), 64'd0);
    move_col = 3'd7; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    chk("t2.illegal_col7", 64'(bus_b.illegal), 64'd1);
    tick();

    // Win on the seventh move, then a request that must be ignored.
    start_game();
    for (int k = 1; k <= 6; k++) do_move(k, 1'b0);
    do_move(1, 1'b1);
    chk("t3.game_over", 64'(bus_a.game_over), 64'd1);
    chk("t3.winner", 64'(bus_b.winner), 64'd0);
    chk("t3.ready", 64'(bus_a.move_ready), 64'd0);
    move_col = 3'd2; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    chk("t3.no_illegal", 64'(bus_a.illegal), 64'd0);
    tick();

    // Full board without a win.
    start_game();
    for (int c = 0; c < 7; c++) for (int r = 0; r < 6; r++) do_move(c, 1'b0);
    chk("t4.draw", 64'(bus_a.draw), 64'd1);
    chk("t4.game_over", 64'(bus_b.game_over), 64'd1);
    chk("t4.draw_cw4", 64'(bus_b.draw), 64'd1);

    // wongame toggling during the settle window: only the resolving edge counts.
    start_game();
    move_col = 3'd3; move_valid = 1'b1; wongame = 1'b0;
    tick();
    move_valid = 1'b0;
    wongame = 1'b1; tick();
    wongame = 1'b0; tick();
    wongame = 1'b1; tick();
    tick();
    wongame = 1'b0; tick();
    chk("t5.done", 64'(bus_b.move_done), 64'd1);
    chk("t5.not_over", 64'(bus_b.game_over), 64'd0);
    chk("t5.player", 64'(bus_b.player), 64'd1);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    repeat (4) tick();
    wongame = 1'b1; tick();
    wongame = 1'b0;
    chk("t5.win_cw4", 64'(bus_b.game_over), 64'd1);
    chk("t5.winner_cw4", 64'(bus_b.winner), 64'd1);
    chk("t5.cw1_running", 64'(bus_a.game_over), 64'd0);
    tick();

    // new_game with a simultaneous request while checking.
    start_game();
    move_col = 3'd2; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    new_game = 1'b1; move_valid = 1'b1; move_col = 3'd5;
    tick();
    new_game = 1'b0; move_valid = 1'b0;
    chk("t6.ng_onoff", 64'(bus_b.onoff_register), 64'd0);
    chk("t6.ng_ready", 64'(bus_b.move_ready), 64'd1);
    chk("t6.ng_done", 64'(bus_b.move_done), 64'd0);
    tick();
    chk("t6.ng_dropped", 64'(bus_b.move_ready), 64'd1);

    // Reset in the middle of a move.
    move_col = 3'd4; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    model_clear(0);
    model_clear(1);
    move_valid = 1'b1;
    tick();
    chk("t6.rst_onoff", 64'(bus_b.onoff_register), 64'd0);
    chk("t6.rst_done", 64'(bus_b.move_done), 64'd0);
    resetn = 1'b1; move_valid = 1'b0;
    tick();
    chk("t6.rst_ready", 64'(bus_b.move_ready), 64'd1);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      new_game   = ($urandom_range(0, 63) == 0);
      move_valid = 1'($urandom_range(0, 1));
      move_col   = 3'($urandom_range(0, 7));
      wongame    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 999) == 0) begin
        resetn = 1'b0;
        model_clear(0);
        model_clear(1);
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
